// File: rtl/param_ramp_gen.sv
// Programmable ramp generator: sawtooth up/down, triangle or hold, with a
// shadowed configuration that is committed only at period boundaries.
module param_ramp_gen #(
   parameter int WIDTH  = 16,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              restart,
   input  logic              cfg_wr,
   input  logic [1:0]        mode_in,
   input  logic [STEP_W-1:0] step_in,
   input  logic [WIDTH-1:0]  lo_in,
   input  logic [WIDTH-1:0]  hi_in,
   output logic [WIDTH-1:0]  ramp,
   output logic              dir,
   output logic              period_done,
   output logic              cfg_pending,
   output logic              cfg_err
);

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_TRI  = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  ramp_q, ramp_d;
   logic              dir_q, dir_d;
   logic              pd_q, pd_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic [1:0]        mode_a_q, mode_a_d, mode_s_q, mode_s_d;
   logic [STEP_W-1:0] step_a_q, step_a_d, step_s_q, step_s_d;
   logic [WIDTH-1:0]  lo_a_q, lo_a_d, lo_s_q, lo_s_d;
   logic [WIDTH-1:0]  hi_a_q, hi_a_d, hi_s_q, hi_s_d;

   logic [WIDTH-1:0]  step_a_ext_s, step_in_ext_s, span_s;
   logic [WIDTH:0]    up_sum_s, lo_step_s;
   logic [WIDTH-1:0]  start_act_s, start_sh_s, step_ramp_s;
   logic              step_dir_s, boundary_s, cfg_valid_s, commit_s;

   // HOLD has no fixed start point, so it resumes from wherever the ramp sits.
   function automatic logic [WIDTH-1:0] start_val(input logic [1:0] mode,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] hi,
                                                 input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] v;
      case (mode)
         MODE_UP:   v = lo;
         MODE_TRI:  v = lo;
         MODE_DOWN: v = hi;
         default:   v = cur;
      endcase
      return v;
   endfunction

   assign step_a_ext_s  = WIDTH'(step_a_q);
   assign step_in_ext_s = WIDTH'(step_in);
   assign span_s        = hi_in - lo_in;
   assign up_sum_s      = {1'b0, ramp_q} + {1'b0, step_a_ext_s};
   assign lo_step_s     = {1'b0, lo_a_q} + {1'b0, step_a_ext_s};
   assign start_act_s   = start_val(mode_a_q, lo_a_q, hi_a_q, ramp_q);
   assign start_sh_s    = start_val(mode_s_q, lo_s_q, hi_s_q, ramp_q);
   assign cfg_valid_s   = (lo_in < hi_in) && (step_in != {STEP_W{1'b0}}) &&
                          (step_in_ext_s <= span_s);

   // Candidate next ramp/dir for one enabled step in the active mode.
   always_comb begin
      step_ramp_s = ramp_q;
      step_dir_s  = dir_q;
      boundary_s  = 1'b0;
      case (mode_a_q)
         MODE_UP: begin
            if (up_sum_s > {1'b0, hi_a_q}) begin
               step_ramp_s = lo_a_q;
               boundary_s  = 1'b1;
            end else begin
               step_ramp_s = up_sum_s[WIDTH-1:0];
            end
         end
         MODE_DOWN: begin
            if ({1'b0, ramp_q} < lo_step_s) begin
               step_ramp_s = hi_a_q;
               boundary_s  = 1'b1;
            end else begin
               step_ramp_s = ramp_q - step_a_ext_s;
            end
         end
         MODE_TRI: begin
            if (!dir_q) begin
               if (up_sum_s >= {1'b0, hi_a_q}) begin
                  step_ramp_s = hi_a_q;
                  step_dir_s  = 1'b1;
               end else begin
                  step_ramp_s = up_sum_s[WIDTH-1:0];
               end
            end else begin
               if ({1'b0, ramp_q} <= lo_step_s) begin
                  step_ramp_s = lo_a_q;
                  step_dir_s  = 1'b0;
                  boundary_s  = 1'b1;
               end else begin
                  step_ramp_s = ramp_q - step_a_ext_s;
               end
            end
         end
         default: begin
            step_ramp_s = ramp_q;
         end
      endcase
   end

   // Sequencing: restart beats commit beats step; shadow capture is independent.
   always_comb begin
      state_d  = state_q;
      ramp_d   = ramp_q;
      dir_d    = dir_q;
      pd_d     = 1'b0;
      commit_s = 1'b0;
      if (restart) begin
         commit_s = pend_q;
         ramp_d   = pend_q ? start_sh_s : start_act_s;
         dir_d    = 1'b0;
         state_d  = en ? RUN : IDLE;
      end else if (state_q == IDLE) begin
         commit_s = pend_q;
         if (en) begin
            ramp_d  = pend_q ? start_sh_s : start_act_s;
            dir_d   = 1'b0;
            state_d = RUN;
         end else begin
            ramp_d = ramp_q;
         end
      end else if (!en) begin
         ramp_d = ramp_q;
      end else if (mode_a_q == MODE_HOLD) begin
         commit_s = pend_q;
         ramp_d   = pend_q ? start_sh_s : ramp_q;
         dir_d    = 1'b0;
      end else if (boundary_s && pend_q) begin
         commit_s = 1'b1;
         ramp_d   = start_sh_s;
         dir_d    = 1'b0;
         pd_d     = 1'b1;
      end else begin
         ramp_d = step_ramp_s;
         dir_d  = step_dir_s;
         pd_d   = boundary_s;
      end

      mode_a_d = commit_s ? mode_s_q : mode_a_q;
      step_a_d = commit_s ? step_s_q : step_a_q;
      lo_a_d   = commit_s ? lo_s_q   : lo_a_q;
      hi_a_d   = commit_s ? hi_s_q   : hi_a_q;
      pend_d   = commit_s ? 1'b0     : pend_q;

      mode_s_d = mode_s_q;
      step_s_d = step_s_q;
      lo_s_d   = lo_s_q;
      hi_s_d   = hi_s_q;
      err_d    = err_q;
      if (cfg_wr) begin
         if (cfg_valid_s) begin
            mode_s_d = mode_in;
            step_s_d = step_in;
            lo_s_d   = lo_in;
            hi_s_d   = hi_in;
            pend_d   = 1'b1;
            err_d    = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         err_d = err_q;
      end
   end

   // State, output and configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ramp_q   <= {WIDTH{1'b0}};
         dir_q    <= 1'b0;
         pd_q     <= 1'b0;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
         mode_a_q <= MODE_UP;
         step_a_q <= STEP_W'(1);
         lo_a_q   <= {WIDTH{1'b0}};
         hi_a_q   <= {WIDTH{1'b1}};
         mode_s_q <= MODE_UP;
         step_s_q <= STEP_W'(1);
         lo_s_q   <= {WIDTH{1'b0}};
         hi_s_q   <= {WIDTH{1'b1}};
      end else begin
         state_q  <= state_d;
         ramp_q   <= ramp_d;
         dir_q    <= dir_d;
         pd_q     <= pd_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         mode_a_q <= mode_a_d;
         step_a_q <= step_a_d;
         lo_a_q   <= lo_a_d;
         hi_a_q   <= hi_a_d;
         mode_s_q <= mode_s_d;
         step_s_q <= step_s_d;
         lo_s_q   <= lo_s_d;
         hi_s_q   <= hi_s_d;
      end
   end

   assign ramp        = ramp_q;
   assign dir         = dir_q;
   assign period_done = pd_q;
   assign cfg_pending = pend_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_param_ramp_gen.sv
// Bench for param_ramp_gen: directed scenarios plus random traffic, all
// checked against a cycle-level reference model written in plain integers.
module tb_param_ramp_gen;

   logic        clk = 1'b0;
   logic        rst_n, en, restart, cfg_wr;
   logic [1:0]  mode_in;
   logic [7:0]  step_in;
   logic [15:0] lo_in, hi_in, ramp;
   logic        dir, period_done, cfg_pending, cfg_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cycle = 0;

   // reference model state
   int m_ramp, m_mode, m_step, m_lo, m_hi, s_mode, s_step, s_lo, s_hi;
   bit m_dir, m_pd, m_pend, m_err, m_run;

   always #5 clk = ~clk;

   param_ramp_gen #(.WIDTH(16), .STEP_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .cfg_wr(cfg_wr),
      .mode_in(mode_in), .step_in(step_in), .lo_in(lo_in), .hi_in(hi_in),
      .ramp(ramp), .dir(dir), .period_done(period_done),
      .cfg_pending(cfg_pending), .cfg_err(cfg_err)
   );

   function automatic int start_of(int md, int l, int h, int r);
      if (md == 0 || md == 2) return l;
      else if (md == 1) return h;
      else return r;
   endfunction

   function automatic logic [19:0] model_vec();
      return {16'(m_ramp), m_dir, m_pd, m_pend, m_err};
   endfunction

   task automatic model_reset();
      m_ramp = 0; m_dir = 0; m_pd = 0; m_pend = 0; m_err = 0; m_run = 0;
      m_mode = 0; m_step = 1; m_lo = 0; m_hi = 65535;
      s_mode = 0; s_step = 1; s_lo = 0; s_hi = 65535;
   endtask

   task automatic model_commit();
      m_mode = s_mode; m_step = s_step; m_lo = s_lo; m_hi = s_hi; m_pend = 0;
   endtask

   // one rising edge of the specified behaviour
   task automatic model_clock(input bit e, input bit r, input bit w,
                              input int md, input int st, input int l, input int h);
      int nxt;
      bit nd, wrap;
      m_pd = 0;
      if (r) begin
         if (m_pend) model_commit();
         m_ramp = start_of(m_mode, m_lo, m_hi, m_ramp);
         m_dir = 0;
         m_run = e;
      end else if (!m_run) begin
         if (m_pend) model_commit();
         if (e) begin
            m_ramp = start_of(m_mode, m_lo, m_hi, m_ramp);
            m_dir = 0;
            m_run = 1;
         end
      end else if (e) begin
         if (m_mode == 3) begin
            if (m_pend) begin
               model_commit();
               m_ramp = start_of(m_mode, m_lo, m_hi, m_ramp);
            end
         end else begin
            nd = m_dir;
            wrap = 0;
            if (m_mode == 0) begin
               wrap = (m_ramp + m_step > m_hi);
               nxt = wrap ? m_lo : m_ramp + m_step;
            end else if (m_mode == 1) begin
               wrap = (m_ramp < m_lo + m_step);
               nxt = wrap ? m_hi : m_ramp - m_step;
            end else if (!m_dir) begin
               nxt = (m_ramp + m_step >= m_hi) ? m_hi : m_ramp + m_step;
               nd = (m_ramp + m_step >= m_hi);
            end else begin
               wrap = (m_ramp <= m_lo + m_step);
               nxt = wrap ? m_lo : m_ramp - m_step;
               nd = !wrap;
            end
            if (wrap && m_pend) begin
               model_commit();
               m_ramp = start_of(m_mode, m_lo, m_hi, m_ramp);
               m_dir = 0;
            end else begin
               m_ramp = nxt;
               m_dir = nd;
            end
            m_pd = wrap;
         end
      end
      if (w) begin
         if (l < h && st != 0 && st <= h - l) begin
            s_mode = md; s_step = st; s_lo = l; s_hi = h;
            m_pend = 1;
            m_err = 0;
         end else begin
            m_err = 1;
         end
      end
   endtask

   task automatic tick(input bit e, input bit r, input bit w,
                       input int md, input int st, input int l, input int h);
      en = e; restart = r; cfg_wr = w;
      mode_in = 2'(md); step_in = 8'(st); lo_in = 16'(l); hi_in = 16'(h);
      @(posedge clk);
      model_clock(e, r, w, md, st, l, h);
      #1;
      cycle++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; restart = 1'b0; cfg_wr = 1'b0;
      mode_in = 2'b00; step_in = 8'd0; lo_in = 16'd0; hi_in = 16'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({ramp, dir, period_done, cfg_pending, cfg_err} !== 20'h00000) begin
         n_bad++;
         $display("FAIL reset_vals got %h expected %h", {ramp, dir, period_done, cfg_pending, cfg_err}, 20'h00000);
      end
      rst_n = 1'b1;
      tick(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec()) begin
         n_bad++;
         $display("FAIL reset_idle got %h expected %h", {ramp, dir, period_done, cfg_pending, cfg_err}, model_vec());
      end
   endtask

   task automatic test_free_run();
      for (int i = 0; i <= 65536; i++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec() ||
             ramp !== 16'(i) || period_done !== (i == 65536)) begin
            n_bad++;
            $display("FAIL free_run i=%0d got ramp=%0d pd=%b expected ramp=%0d pd=%b",
                     i, ramp, period_done, i % 65536, (i == 65536));
         end
      end
   endtask

   task automatic test_saw_cfg();
      int exp_r[7] = '{10, 13, 16, 16, 16, 19, 10};
      bit exp_p[7] = '{0, 0, 0, 0, 0, 0, 1};
      bit ens[7]   = '{1, 1, 1, 0, 0, 1, 1};
      tick(0, 1, 0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 3, 10, 20);
      tick(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         tick(ens[i], 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec() ||
             ramp !== 16'(exp_r[i]) || period_done !== exp_p[i]) begin
            n_bad++;
            $display("FAIL saw_cfg i=%0d got ramp=%0d pd=%b expected ramp=%0d pd=%b",
                     i, ramp, period_done, exp_r[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_tri();
      int exp_r[8] = '{0, 4, 8, 10, 6, 2, 0, 4};
      bit exp_d[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
      bit exp_p[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      tick(0, 0, 1, 2, 4, 0, 10);
      for (int i = 0; i < 8; i++) begin
         tick(1, (i == 0), 0, 0, 0, 0, 0);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec() ||
             ramp !== 16'(exp_r[i]) || dir !== exp_d[i] || period_done !== exp_p[i]) begin
            n_bad++;
            $display("FAIL tri i=%0d got ramp=%0d dir=%b pd=%b expected ramp=%0d dir=%b pd=%b",
                     i, ramp, dir, period_done, exp_r[i], exp_d[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_pending_commit();
      int exp_r[3] = '{55, 50, 60};
      bit seen = 0;
      tick(0, 0, 1, 0, 10, 0, 100);
      tick(1, 1, 0, 0, 0, 0, 0);
      repeat (4) tick(1, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 1, 1, 5, 50, 60);
      n_cmp++;
      if (ramp !== 16'd50 || cfg_pending !== 1'b1) begin
         n_bad++;
         $display("FAIL pend_set got ramp=%0d pend=%b expected ramp=50 pend=1", ramp, cfg_pending);
      end
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         seen = period_done;
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec()) begin
            n_bad++;
            $display("FAIL pend_run i=%0d got %h expected %h", i, {ramp, dir, period_done, cfg_pending, cfg_err}, model_vec());
         end
      end
      n_cmp++;
      if (!seen || ramp !== 16'd60 || cfg_pending !== 1'b0) begin
         n_bad++;
         $display("FAIL pend_commit got seen=%b ramp=%0d pend=%b expected seen=1 ramp=60 pend=0", seen, ramp, cfg_pending);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec() || ramp !== 16'(exp_r[i])) begin
            n_bad++;
            $display("FAIL pend_after i=%0d got ramp=%0d expected ramp=%0d", i, ramp, exp_r[i]);
         end
      end
   endtask

   task automatic test_cfg_err();
      tick(1, 0, 1, 0, 3, 20, 20);
      n_cmp++;
      if (cfg_err !== 1'b1 || cfg_pending !== 1'b0) begin
         n_bad++;
         $display("FAIL err_eq got err=%b pend=%b expected err=1 pend=0", cfg_err, cfg_pending);
      end
      tick(1, 0, 1, 0, 0, 0, 50);
      for (int i = 0; i < 6; i++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec() || cfg_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky i=%0d got %h expected %h", i, {ramp, dir, period_done, cfg_pending, cfg_err}, model_vec());
         end
      end
      tick(1, 0, 1, 0, 2, 0, 50);
      n_cmp++;
      if (cfg_err !== 1'b0 || cfg_pending !== 1'b1) begin
         n_bad++;
         $display("FAIL err_clear got err=%b pend=%b expected err=0 pend=1", cfg_err, cfg_pending);
      end
   endtask

   task automatic test_restart_commit();
      tick(1, 0, 1, 2, 3, 100, 200);
      tick(1, 1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (ramp !== 16'd100 || cfg_pending !== 1'b0 || period_done !== 1'b0 || dir !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_commit got ramp=%0d pend=%b pd=%b dir=%b expected 100 0 0 0", ramp, cfg_pending, period_done, dir);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec() || ramp !== 16'(103 + 3 * i)) begin
            n_bad++;
            $display("FAIL restart_run i=%0d got ramp=%0d expected ramp=%0d", i, ramp, 103 + 3 * i);
         end
      end
   endtask

   task automatic test_async_reset();
      tick(1, 0, 1, 1, 7, 30, 90);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({ramp, dir, period_done, cfg_pending, cfg_err} !== 20'h00000) begin
         n_bad++;
         $display("FAIL async_reset got %h expected %h", {ramp, dir, period_done, cfg_pending, cfg_err}, 20'h00000);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec() || ramp !== 16'(i)) begin
            n_bad++;
            $display("FAIL post_reset i=%0d got ramp=%0d expected ramp=%0d", i, ramp, i);
         end
      end
   endtask

   task automatic test_random();
      int l, h;
      for (int i = 0; i < 4000; i++) begin
         l = $urandom_range(0, 300);
         h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 600) : l + $urandom_range(0, 300);
         tick($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 3), $urandom_range(0, 40), l, h);
         n_cmp++;
         if ({ramp, dir, period_done, cfg_pending, cfg_err} !== model_vec()) begin
            n_bad++;
            $display("FAIL random i=%0d got ramp=%0d dir=%b pd=%b pend=%b err=%b expected ramp=%0d dir=%b pd=%b pend=%b err=%b",
                     i, ramp, dir, period_done, cfg_pending, cfg_err, m_ramp, m_dir, m_pd, m_pend, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_saw_cfg();
      test_tri();
      test_pending_commit();
      test_cfg_err();
      test_restart_commit();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
